// File: rtl/direction_queue_pkg.sv
// Shared constants for the direction queue: one-hot directions, PS/2 scan
// codes, parser state encoding and a direction-reversal helper.
package direction_queue_pkg;

    localparam int unsigned DIR_W   = 5;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned PST_W   = 2;

    // One-hot applied directions
    localparam logic [DIR_W-1:0] DIR_NONE  = 5'b00000;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 5'b00001;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 5'b00010;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 5'b00100;
    localparam logic [DIR_W-1:0] DIR_UP    = 5'b01000;
    localparam logic [DIR_W-1:0] DIR_STOP  = 5'b10000;

    // PS/2 set-2 prefixes
    localparam logic [BYTE_W-1:0] SC_EXT       = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_BRK       = 8'hF0;
    // Extended (arrow) make codes
    localparam logic [BYTE_W-1:0] SC_EXT_RIGHT = 8'h74;
    localparam logic [BYTE_W-1:0] SC_EXT_DOWN  = 8'h72;
    localparam logic [BYTE_W-1:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [BYTE_W-1:0] SC_EXT_UP    = 8'h75;
    // Plain make codes
    localparam logic [BYTE_W-1:0] SC_D         = 8'h23;
    localparam logic [BYTE_W-1:0] SC_S         = 8'h1B;
    localparam logic [BYTE_W-1:0] SC_A         = 8'h1C;
    localparam logic [BYTE_W-1:0] SC_W         = 8'h1D;
    localparam logic [BYTE_W-1:0] SC_SPACE     = 8'h29;

    // Parser states
    localparam logic [PST_W-1:0] PST_IDLE    = 2'd0;
    localparam logic [PST_W-1:0] PST_EXT     = 2'd1;
    localparam logic [PST_W-1:0] PST_BRK     = 2'd2;
    localparam logic [PST_W-1:0] PST_EXT_BRK = 2'd3;

    // 180-degree opposite: swap RIGHT<->LEFT and DOWN<->UP, STOP unchanged
    function automatic logic [DIR_W-1:0] dir_opposite(input logic [DIR_W-1:0] d);
        return {d[4], d[1:0], d[3:2]};
    endfunction

endpackage

// File: rtl/direction_queue_parser.sv
// PS/2 scan-code parser: tracks E0/F0 prefixes and decodes make codes into a
// one-hot direction. Outputs are combinational and valid in the cycle of the
// final key_valid byte.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_clear          : synchronous return to IDLE
//   i_key_data/valid : scan-code byte and its strobe
//   o_dir_c          : decoded one-hot direction (zero when none)
//   o_valid_c        : one-cycle strobe qualifying o_dir_c
module ps2_dir_parser
    import direction_queue_pkg::*;
#(
    parameter int unsigned WASD_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic [BYTE_W-1:0] i_key_data,
    input  logic              i_key_valid,
    output logic [DIR_W-1:0]  o_dir_c,
    output logic              o_valid_c
);

    logic [PST_W-1:0] r_state;
    logic [PST_W-1:0] w_state_nxt;
    logic [DIR_W-1:0] w_dir;

    function automatic logic [DIR_W-1:0] decode_plain(input logic [BYTE_W-1:0] b);
        logic [DIR_W-1:0] d;
        d = DIR_NONE;
        if (b == SC_SPACE) begin
            d = DIR_STOP;
        end else if (WASD_EN != 0) begin
            case (b)
                SC_D:    d = DIR_RIGHT;
                SC_S:    d = DIR_DOWN;
                SC_A:    d = DIR_LEFT;
                SC_W:    d = DIR_UP;
                default: d = DIR_NONE;
            endcase
        end
        return d;
    endfunction

    function automatic logic [DIR_W-1:0] decode_ext(input logic [BYTE_W-1:0] b);
        logic [DIR_W-1:0] d;
        case (b)
            SC_EXT_RIGHT: d = DIR_RIGHT;
            SC_EXT_DOWN:  d = DIR_DOWN;
            SC_EXT_LEFT:  d = DIR_LEFT;
            SC_EXT_UP:    d = DIR_UP;
            default:      d = DIR_NONE;
        endcase
        return d;
    endfunction

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= PST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and decode
    always_comb begin
        w_state_nxt = r_state;
        w_dir       = DIR_NONE;
        if (i_clear) begin
            w_state_nxt = PST_IDLE;
        end else if (i_key_valid) begin
            case (r_state)
                PST_IDLE: begin
                    if (i_key_data == SC_EXT) begin
                        w_state_nxt = PST_EXT;
                    end else if (i_key_data == SC_BRK) begin
                        w_state_nxt = PST_BRK;
                    end else begin
                        w_dir = decode_plain(i_key_data);
                    end
                end
                PST_EXT: begin
                    if (i_key_data == SC_BRK) begin
                        w_state_nxt = PST_EXT_BRK;
                    end else begin
                        w_dir       = decode_ext(i_key_data);
                        w_state_nxt = PST_IDLE;
                    end
                end
                // Break-code byte is swallowed
                default: w_state_nxt = PST_IDLE;
            endcase
        end
    end

    assign o_dir_c   = w_dir;
    assign o_valid_c = |w_dir;

endmodule

// File: rtl/direction_queue.sv
// Snake-game turn queue: parses PS/2 scan codes into directions, rejects
// no-op and reversing turns, buffers accepted turns and applies one per step.
//   clk, reset   : clock, async active-low reset
//   key_data     : PS/2 scan-code byte, qualified by key_valid
//   step         : game tick, pops one queued turn
//   clear        : synchronous flush to STOP with empty queue
//   direction    : one-hot applied direction
//   queue_count  : pending turns
//   overflow     : one-cycle pulse when an accepted turn is dropped
module direction_queue
    import direction_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned WASD_EN = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 key_data,
    input  logic                       key_valid,
    input  logic                       step,
    input  logic                       clear,
    output logic [4:0]                 direction,
    output logic [$clog2(DEPTH+1)-1:0] queue_count,
    output logic                       overflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DIR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DIR_W-1:0] r_dir;
    logic             r_overflow;

    logic [DIR_W-1:0] w_dec_dir;
    logic             w_dec_valid;
    logic [PTR_W-1:0] w_tail_ptr;
    logic [DIR_W-1:0] w_ref;
    logic             w_empty;
    logic             w_full;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    ps2_dir_parser #(
        .WASD_EN (WASD_EN)
    ) u_parser (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_clear     (clear),
        .i_key_data  (key_data),
        .i_key_valid (key_valid),
        .o_dir_c     (w_dec_dir),
        .o_valid_c   (w_dec_valid)
    );

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_tail_ptr = r_wr_ptr - PTR_W'(1);
    // New turns are judged against the last queued turn, else the live one
    assign w_ref      = w_empty ? r_dir : r_mem[w_tail_ptr];

    // Turn acceptance: no repeats, no reversals, STOP only once
    always_comb begin
        w_accept = 1'b0;
        if (w_dec_valid) begin
            if (w_dec_dir == DIR_STOP) begin
                w_accept = (w_ref != DIR_STOP);
            end else if (w_ref == DIR_STOP) begin
                w_accept = 1'b1;
            end else begin
                w_accept = (w_dec_dir != w_ref) && (w_dec_dir != dir_opposite(w_ref));
            end
        end
    end

    // A pop in the same cycle frees the slot, so a full queue can still push
    assign w_pop  = step && !w_empty;
    assign w_push = w_accept && (!w_full || w_pop);
    assign w_drop = w_accept && w_full && !w_pop;

    // Queue storage, pointers and applied direction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= DIR_NONE;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dir      <= DIR_STOP;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dir      <= DIR_STOP;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec_dir;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_dir    <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign direction   = r_dir;
    assign queue_count = r_count;
    assign overflow    = r_overflow;

endmodule

// File: doc/direction_queue.md
DIRECTION_QUEUE -- requirements
Module: direction_queue

Interface
REQ-001 Parameter DEPTH, default 4, turn-queue entries; power of two, 2..16.
REQ-002 Parameter WASD_EN, default 1; 1 = WASD keys decoded in addition to arrow keys.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port key_data  input  8  PS/2 scan-code byte.
REQ-006 Port key_valid  input  1  one-cycle strobe qualifying key_data.
REQ-007 Port step  input  1  one-cycle game-tick strobe; pops one queued turn.
REQ-008 Port clear  input  1  synchronous flush (game over/restart).
REQ-009 Port direction  output  5  one-hot applied direction: [0] RIGHT, [1] DOWN, [2] LEFT, [3] UP, [4] STOP.
REQ-010 Port queue_count  output  $clog2(DEPTH+1)  number of pending turns.
REQ-011 Port overflow  output  1  one-cycle pulse when a valid turn is dropped because the queue is full.

Function
REQ-012 Scan-code parser SHALL be an FSM with states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), advancing only on key_valid.
REQ-013 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> decode as plain make code, stay in IDLE.
REQ-014 EXT: F0 -> EXT_BRK; any other byte -> decode as extended make code, return to IDLE.
REQ-015 BRK and EXT_BRK: next byte is discarded (break code), return to IDLE.
REQ-016 Extended make codes: 74 RIGHT, 72 DOWN, 6B LEFT, 75 UP; any other extended byte is ignored.
REQ-017 Plain make codes when WASD_EN=1: 23 (D) RIGHT, 1B (S) DOWN, 1C (A) LEFT, 1D (W) UP; 29 (space) STOP in all configurations; all other bytes ignored.
REQ-018 Reference direction = tail entry if queue_count>0, otherwise the current direction output.
REQ-019 A decoded turn SHALL be rejected if it equals the reference direction or is its 180-degree opposite; no check applies when the reference is STOP.
REQ-020 A decoded STOP SHALL be accepted unless the reference is already STOP.
REQ-021 An accepted turn SHALL be written at the queue tail one cycle after its final key_valid byte; it is not visible on direction before the next step.
REQ-022 On step with queue_count>0, head entry SHALL appear on direction the following cycle and queue_count decrements; on step with empty queue, direction holds.
REQ-023 Accepted turn with queue full and no step in the same cycle: turn dropped, overflow pulses one cycle, queue unchanged.
REQ-024 Accepted turn and step in the same cycle: pop and push both occur, queue_count unchanged, including when full (no overflow).
REQ-025 Push/pop pointers SHALL wrap modulo DEPTH; queue_count SHALL never exceed DEPTH or underflow.
REQ-026 clear SHALL, next cycle: empty the queue, set direction to STOP, return parser to IDLE; clear has priority over step and key_valid in that cycle.

Reset
REQ-027 While reset is low: direction = 5'b10000 (STOP), queue_count = 0, overflow = 0, parser in IDLE, pointers = 0.
REQ-028 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial scan code; first byte after release is parsed from IDLE.

Structure
REQ-029 Shared package SHALL hold the one-hot direction constants (RIGHT, DOWN, LEFT, UP, STOP), the scan-code constants, and the parser-state enumeration.
REQ-030 Parser SHALL be a sub-module ps2_dir_parser (outputs: decoded-direction one-hot plus a one-cycle valid); queue and reversal check remain in direction_queue.
REQ-031 Queue storage SHALL be a register array of DEPTH x 5 bits; no RAM primitive.

Verification
REQ-032 Reset release, then E0,75 and a step -> direction 01000 (UP) one cycle after step; queue_count 1 then 0.
REQ-033 direction=UP, bytes E0,72 (DOWN) -> rejected, queue_count stays 0; bytes E0,6B, step -> direction 00100 (LEFT).
REQ-034 DEPTH=4, direction=RIGHT, alternating UP/RIGHT entered five times (UP,RIGHT,UP,RIGHT,UP) without step -> queue_count 4, overflow pulse on the fifth turn; four steps yield UP,RIGHT,UP,RIGHT.
REQ-035 Break sequence E0,F0,75 then plain F0,1D -> no queue change, parser back in IDLE; next E0,74 is accepted as RIGHT.
REQ-036 Queue full and turn accepted in the same cycle as step -> queue_count stays 4, no overflow, head advances.
REQ-037 Queue holds 3 entries, direction=LEFT, clear pulse with simultaneous step -> next cycle direction 10000, queue_count 0; reset pulled low after E0 -> following byte 75 is ignored.
